// File: rtl/fuec_stream_decoder.sv
// Two-stage valid/ready stream front end for the FUEC (12,8) code: per-lane decode,
// redundancy-only error classification, saturating event counters and first-correction capture.

module fuec_encoder_12_8 (
  input  logic [7:0] i_data,
  output logic [3:0] o_red_c
);
  // Redundancy bit j is the parity of the data bits whose H-matrix column has bit j set.
  assign o_red_c[0] = ^(i_data & 8'hCB);
  assign o_red_c[1] = ^(i_data & 8'hD5);
  assign o_red_c[2] = ^(i_data & 8'h66);
  assign o_red_c[3] = ^(i_data & 8'hB8);
endmodule

module fuec_decoder_interface (
  input  logic [11:0] i_cw,
  output logic [7:0]  o_data_dec_c,
  output logic [7:0]  o_pos_error_c
);
  logic [3:0] w_parity;
  logic [3:0] w_syn;

  fuec_encoder_12_8 u_enc (
    .i_data  (i_cw[7:0]),
    .o_red_c (w_parity)
  );

  assign w_syn = w_parity ^ i_cw[11:8];

  // Weight-1 syndromes point at a redundancy bit and leave the data untouched.
  always_comb begin
    o_pos_error_c = '0;
    case (w_syn)
      4'h3:    o_pos_error_c[0] = 1'b1;
      4'h5:    o_pos_error_c[1] = 1'b1;
      4'h6:    o_pos_error_c[2] = 1'b1;
      4'h9:    o_pos_error_c[3] = 1'b1;
      4'hA:    o_pos_error_c[4] = 1'b1;
      4'hC:    o_pos_error_c[5] = 1'b1;
      4'h7:    o_pos_error_c[6] = 1'b1;
      4'hB:    o_pos_error_c[7] = 1'b1;
      default: o_pos_error_c = '0;
    endcase
  end

  assign o_data_dec_c = i_cw[7:0] ^ o_pos_error_c;
endmodule

module fuec_stream_decoder #(
  parameter  int unsigned LANES  = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [12*LANES-1:0]   in_cw,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*LANES-1:0]    out_data,
  output logic [8*LANES-1:0]    out_pos,
  output logic [LANES-1:0]      out_corr,
  output logic [LANES-1:0]      out_red_err,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      corr_cnt,
  output logic [CNT_W-1:0]      red_cnt,
  output logic                  cap_valid,
  output logic [LANE_W-1:0]     cap_lane,
  output logic [7:0]            cap_pos
);
  localparam int unsigned CW_W  = 12 * LANES;
  localparam int unsigned D_W   = 8 * LANES;
  localparam int unsigned SUM_W = CNT_W + 5;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((64'd1 << CNT_W) - 64'd1);

  logic              r_s1_v;
  logic [CW_W-1:0]   r_s1_cw;
  logic              r_s2_v;
  logic [D_W-1:0]    r_out_data;
  logic [D_W-1:0]    r_out_pos;
  logic [LANES-1:0]  r_out_corr;
  logic [LANES-1:0]  r_out_red_err;
  logic [CNT_W-1:0]  r_corr_cnt;
  logic [CNT_W-1:0]  r_red_cnt;
  logic              r_cap_valid;
  logic [LANE_W-1:0] r_cap_lane;
  logic [7:0]        r_cap_pos;

  logic              w_s2_load;
  logic              w_s1_adv;
  logic              w_s1_load;
  logic              w_hs;
  logic [D_W-1:0]    w_dec_data;
  logic [D_W-1:0]    w_dec_pos;
  logic [LANES-1:0]  w_corr;
  logic [LANES-1:0]  w_red_err;
  logic [SUM_W-1:0]  w_corr_sum;
  logic [SUM_W-1:0]  w_red_sum;
  logic [CNT_W-1:0]  w_corr_next;
  logic [CNT_W-1:0]  w_red_next;
  logic [LANE_W-1:0] w_first_lane;
  logic [7:0]        w_first_pos;

  function automatic logic [4:0] popcount(input logic [LANES-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < int'(LANES); i++) n = n + 5'(v[i]);
    return n;
  endfunction

  assign w_s2_load = !r_s2_v || out_ready;
  assign w_s1_adv  = r_s1_v && w_s2_load;
  assign w_s1_load = !r_s1_v || w_s1_adv;
  assign w_hs      = r_s2_v && out_ready;
  assign in_ready  = rst_n && w_s1_load;

  // Per-lane decode of S1 plus re-encode of the corrected data to expose parity-only errors.
  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    logic [3:0] w_reenc;

    fuec_decoder_interface u_dec (
      .i_cw          (r_s1_cw[12*k +: 12]),
      .o_data_dec_c  (w_dec_data[8*k +: 8]),
      .o_pos_error_c (w_dec_pos[8*k +: 8])
    );

    fuec_encoder_12_8 u_reenc (
      .i_data  (w_dec_data[8*k +: 8]),
      .o_red_c (w_reenc)
    );

    assign w_corr[k]    = |w_dec_pos[8*k +: 8];
    assign w_red_err[k] = !w_corr[k] && (w_reenc != r_s1_cw[12*k+8 +: 4]);
  end

  assign w_corr_sum  = SUM_W'(r_corr_cnt) + SUM_W'(popcount(r_out_corr));
  assign w_red_sum   = SUM_W'(r_red_cnt) + SUM_W'(popcount(r_out_red_err));
  assign w_corr_next = (w_corr_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(w_corr_sum);
  assign w_red_next  = (w_red_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(w_red_sum);

  // Scan from the top so the lowest corrected lane is the one that sticks.
  always_comb begin
    w_first_lane = '0;
    w_first_pos  = '0;
    for (int k = int'(LANES) - 1; k >= 0; k--) begin
      if (r_out_corr[k]) begin
        w_first_lane = LANE_W'(k);
        w_first_pos  = r_out_pos[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v        <= 1'b0;
      r_s1_cw       <= '0;
      r_s2_v        <= 1'b0;
      r_out_data    <= '0;
      r_out_pos     <= '0;
      r_out_corr    <= '0;
      r_out_red_err <= '0;
      r_corr_cnt    <= '0;
      r_red_cnt     <= '0;
      r_cap_valid   <= 1'b0;
      r_cap_lane    <= '0;
      r_cap_pos     <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_v <= in_valid;
        if (in_valid) r_s1_cw <= in_cw;
      end
      if (w_s2_load) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_out_data    <= w_dec_data;
          r_out_pos     <= w_dec_pos;
          r_out_corr    <= w_corr;
          r_out_red_err <= w_red_err;
        end
      end
      // A clear on the handshake edge discards that beat's statistics.
      if (clr_cnt) begin
        r_corr_cnt  <= '0;
        r_red_cnt   <= '0;
        r_cap_valid <= 1'b0;
        r_cap_lane  <= '0;
        r_cap_pos   <= '0;
      end else if (w_hs) begin
        r_corr_cnt <= w_corr_next;
        r_red_cnt  <= w_red_next;
        if (!r_cap_valid && |r_out_corr) begin
          r_cap_valid <= 1'b1;
          r_cap_lane  <= w_first_lane;
          r_cap_pos   <= w_first_pos;
        end
      end
    end
  end

  assign out_valid   = r_s2_v;
  assign out_data    = r_out_data;
  assign out_pos     = r_out_pos;
  assign out_corr    = r_out_corr;
  assign out_red_err = r_out_red_err;
  assign corr_cnt    = r_corr_cnt;
  assign red_cnt     = r_red_cnt;
  assign cap_valid   = r_cap_valid;
  assign cap_lane    = r_cap_lane;
  assign cap_pos     = r_cap_pos;
endmodule

// File: tb/tb_fuec_stream_decoder.sv
// Bench for fuec_stream_decoder: directed steps plus random traffic against a
// beat-level reference model (nearest-codeword decode, queue, saturating counters).

module tb_fuec_stream_decoder;
  localparam int unsigned LANES = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pos;
    logic [3:0]  corr;
    logic [3:0]  red;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [47:0] in_cw;
  logic        out_ready;
  logic        clr_cnt;

  logic        in_ready, out_valid, cap_valid;
  logic [31:0] out_data, out_pos;
  logic [3:0]  out_corr, out_red_err;
  logic [15:0] corr_cnt, red_cnt;
  logic [1:0]  cap_lane;
  logic [7:0]  cap_pos;

  logic        in_ready_s, out_valid_s, cap_valid_s;
  logic [31:0] out_data_s, out_pos_s;
  logic [3:0]  out_corr_s, out_red_err_s;
  logic [1:0]  corr_cnt_s, red_cnt_s;
  logic [1:0]  cap_lane_s;
  logic [7:0]  cap_pos_s;

  int total = 0;
  int bad   = 0;

  int          rdy_mode;
  logic        rdy_fixed;
  logic [15:0] rdy_pat;
  int          rdy_idx = 0;

  beat_t q[$];
  beat_t mb;
  int    m_corr, m_red, m_corr_s, m_red_s;
  logic  m_cap_v;
  int    m_cap_lane;
  logic [7:0] m_cap_pos;

  fuec_stream_decoder #(.LANES(LANES), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pos(out_pos),
    .out_corr(out_corr), .out_red_err(out_red_err), .clr_cnt(clr_cnt),
    .corr_cnt(corr_cnt), .red_cnt(red_cnt), .cap_valid(cap_valid),
    .cap_lane(cap_lane), .cap_pos(cap_pos)
  );

  fuec_stream_decoder #(.LANES(LANES), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_cw(in_cw),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_pos(out_pos_s),
    .out_corr(out_corr_s), .out_red_err(out_red_err_s), .clr_cnt(clr_cnt),
    .corr_cnt(corr_cnt_s), .red_cnt(red_cnt_s), .cap_valid(cap_valid_s),
    .cap_lane(cap_lane_s), .cap_pos(cap_pos_s)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] enc(input logic [7:0] d);
    return {^(d & 8'hB8), ^(d & 8'h66), ^(d & 8'hD5), ^(d & 8'hCB)};
  endfunction

  function automatic logic [47:0] clean(input logic [7:0] d);
    logic [11:0] l;
    l = {enc(d), d};
    return {4{l}};
  endfunction

  // Reference decode: a lane is corrected iff flipping exactly one data bit yields a valid codeword.
  function automatic beat_t exp_beat(input logic [47:0] cw);
    beat_t b;
    logic [7:0] d, p;
    logic [3:0] r;
    b = '0;
    for (int k = 0; k < 4; k++) begin
      d = cw[12*k +: 8];
      r = cw[12*k+8 +: 4];
      p = 8'h00;
      for (int i = 0; i < 8; i++)
        if (enc(d ^ 8'(1 << i)) == r) p = 8'(1 << i);
      b.data[8*k +: 8] = d ^ p;
      b.pos[8*k +: 8]  = p;
      b.corr[k]        = (p != 8'h00);
      b.red[k]         = (p == 8'h00) && (enc(d) != r);
    end
    return b;
  endfunction

  function automatic logic [47:0] rand_cw();
    logic [47:0] cw;
    logic [11:0] l;
    logic [7:0]  d;
    int n;
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      l = {enc(d), d};
      n = $urandom_range(0, 2);
      for (int e = 0; e < n; e++) l[$urandom_range(0, 11)] ^= 1'b1;
      cw[12*k +: 12] = l;
    end
    return cw;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = rdy_fixed;
      1: begin
        out_ready = rdy_pat[rdy_idx % 16];
        rdy_idx++;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    chk("corr_cnt", 64'(corr_cnt), 64'(m_corr));
    chk("red_cnt", 64'(red_cnt), 64'(m_red));
    chk("cap_valid", 64'(cap_valid), 64'(m_cap_v));
    chk("cap_lane", 64'(cap_lane), 64'(m_cap_lane));
    chk("cap_pos", 64'(cap_pos), 64'(m_cap_pos));
    chk("sat_corr_cnt", 64'(corr_cnt_s), 64'(m_corr_s));
    chk("sat_red_cnt", 64'(red_cnt_s), 64'(m_red_s));
    chk("sat_cap_valid", 64'(cap_valid_s), 64'(m_cap_v));
    chk("sat_cap_lane", 64'(cap_lane_s), 64'(m_cap_lane));
    chk("sat_cap_pos", 64'(cap_pos_s), 64'(m_cap_pos));
    if (out_valid) begin
      chk("out_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        chk("out_data", 64'(out_data), 64'(q[0].data));
        chk("out_pos", 64'(out_pos), 64'(q[0].pos));
        chk("out_corr", 64'(out_corr), 64'(q[0].corr));
        chk("out_red_err", 64'(out_red_err), 64'(q[0].red));
        chk("sat_out_data", 64'(out_data_s), 64'(q[0].data));
        chk("sat_out_pos", 64'(out_pos_s), 64'(q[0].pos));
        chk("sat_out_corr", 64'(out_corr_s), 64'(q[0].corr));
        chk("sat_out_red_err", 64'(out_red_err_s), 64'(q[0].red));
      end
    end
    if (!rst_n) begin
      q.delete();
      m_corr = 0; m_red = 0; m_corr_s = 0; m_red_s = 0;
      m_cap_v = 1'b0; m_cap_lane = 0; m_cap_pos = 8'h00;
    end else begin
      if (clr_cnt) begin
        m_corr = 0; m_red = 0; m_corr_s = 0; m_red_s = 0;
        m_cap_v = 1'b0; m_cap_lane = 0; m_cap_pos = 8'h00;
      end
      if (out_valid && out_ready && q.size() != 0) begin
        mb = q.pop_front();
        if (!clr_cnt) begin
          m_corr   = (m_corr + $countones(mb.corr) > 65535) ? 65535 : m_corr + $countones(mb.corr);
          m_red    = (m_red + $countones(mb.red) > 65535) ? 65535 : m_red + $countones(mb.red);
          m_corr_s = (m_corr_s + $countones(mb.corr) > 3) ? 3 : m_corr_s + $countones(mb.corr);
          m_red_s  = (m_red_s + $countones(mb.red) > 3) ? 3 : m_red_s + $countones(mb.red);
          if (!m_cap_v && mb.corr != 4'h0) begin
            m_cap_v = 1'b1;
            for (int k = 3; k >= 0; k--)
              if (mb.corr[k]) begin
                m_cap_lane = k;
                m_cap_pos  = mb.pos[8*k +: 8];
              end
          end
        end
      end
      if (in_valid && in_ready) q.push_back(exp_beat(in_cw));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] cw);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_cw = cw;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
  endtask

  initial begin
    logic [47:0] cw;
    rst_n = 1'b0; in_valid = 1'b0; in_cw = '0; clr_cnt = 1'b0;
    rdy_mode = 0; rdy_fixed = 1'b1; rdy_pat = 16'b1110_1001_1010_1001;
    m_corr = 0; m_red = 0; m_corr_s = 0; m_red_s = 0;
    m_cap_v = 1'b0; m_cap_lane = 0; m_cap_pos = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_pos", 64'(out_pos), 64'd0);
    chk("rst_out_corr", 64'(out_corr), 64'd0);
    chk("rst_out_red_err", 64'(out_red_err), 64'd0);
    chk("rst_sat_in_ready", 64'(in_ready_s), 64'd0);
    chk("rst_sat_out_valid", 64'(out_valid_s), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Two-cycle latency
    step();
    in_valid = 1'b1;
    in_cw = clean(8'hAC);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_edge1_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_edge2_out_valid", 64'(out_valid), 64'd1);
    step();
    drain();

    // Clean stream
    for (int b = 0; b < 8; b++) send(clean(8'hAC));
    drain();
    @(negedge clk);
    chk("clean_corr_cnt", 64'(corr_cnt), 64'd0);
    chk("clean_red_cnt", 64'(red_cnt), 64'd0);
    step();

    // Single-bit sweep on lane 2
    pulse_clr();
    for (int i = 0; i < 8; i++) begin
      cw = clean(8'hAC);
      cw[24 + i] = ~cw[24 + i];
      send(cw);
    end
    drain();
    @(negedge clk);
    chk("sweep_corr_cnt", 64'(corr_cnt), 64'd8);
    chk("sweep_cap_valid", 64'(cap_valid), 64'd1);
    chk("sweep_cap_lane", 64'(cap_lane), 64'd2);
    chk("sweep_cap_pos", 64'(cap_pos), 64'h01);
    step();

    // Parity-only flips on lane 0
    pulse_clr();
    for (int b = 8; b < 12; b++) begin
      cw = clean(8'hAC);
      cw[b] = ~cw[b];
      send(cw);
    end
    drain();
    @(negedge clk);
    chk("parity_red_cnt", 64'(red_cnt), 64'd4);
    chk("parity_corr_cnt", 64'(corr_cnt), 64'd0);
    chk("parity_cap_valid", 64'(cap_valid), 64'd0);
    step();

    // Stalled output: two beats held, in_ready low
    rdy_fixed = 1'b0;
    step();
    step();
    send(rand_cw());
    send(rand_cw());
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    step();
    cw = rand_cw();
    in_valid = 1'b1;
    in_cw = cw;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_hold_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    rdy_fixed = 1'b1;
    send(cw);
    drain();

    // Toggling out_ready
    rdy_mode = 1;
    for (int b = 0; b < 6; b++) send(rand_cw());
    drain();

    // Random traffic with random backpressure and occasional clears
    rdy_mode = 2;
    for (int b = 0; b < 300; b++) begin
      if ($urandom_range(0, 3) == 0) step();
      clr_cnt = ($urandom_range(0, 30) == 0);
      send(rand_cw());
      clr_cnt = 1'b0;
    end
    drain();
    rdy_mode = 0;
    rdy_fixed = 1'b1;
    step();
    step();

    // Saturation with corrections in lanes 0 and 3
    pulse_clr();
    for (int b = 0; b < 5; b++) begin
      cw = clean(8'($urandom));
      cw[$urandom_range(0, 7)] ^= 1'b1;
      cw[36 + $urandom_range(0, 7)] ^= 1'b1;
      send(cw);
    end
    drain();
    @(negedge clk);
    chk("sat_corr_held", 64'(corr_cnt_s), 64'd3);
    chk("sat_main_corr", 64'(corr_cnt), 64'd10);
    chk("sat_cap_lane0", 64'(cap_lane_s), 64'd0);
    step();

    // Clear coinciding with a corrected handshake
    cw = clean(8'h5A);
    cw[40] = ~cw[40];
    send(cw);
    step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_corr_cnt", 64'(corr_cnt), 64'd0);
    chk("clr_sat_corr_cnt", 64'(corr_cnt_s), 64'd0);
    chk("clr_cap_valid", 64'(cap_valid), 64'd0);
    chk("clr_sat_cap_valid", 64'(cap_valid_s), 64'd0);
    step();
    drain();

    // Reset with two beats in flight
    cw = clean(8'h33);
    cw[3] = ~cw[3];
    send(cw);
    drain();
    send(cw);
    send(rand_cw());
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_corr_cnt", 64'(corr_cnt), 64'd0);
    chk("midrst_red_cnt", 64'(red_cnt), 64'd0);
    chk("midrst_cap_valid", 64'(cap_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    step();
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) send(rand_cw());
    drain();

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
